// File: rtl/parity_tx.sv
// parity_tx: serial frame generator with a ninth (parity) bit.
// Frame on tx_out: start (0), data[0..7] LSB first, parity, stop (1),
// each bit held for CLKS_PER_BIT clocks. The last stop-bit cycle doubles as
// the IDLE/done cycle, so a load seen there starts the next frame with no gap.
module parity_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       odd_sel,
    input  logic       load,
    output logic       ready,
    output logic       tx_out,
    output logic       parity_bit,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Counter value on the final cycle of a normal bit.
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    // STOP lasts one cycle less than a bit; its final cycle is spent in IDLE.
    localparam logic [15:0] STOP_LAST = (CLKS_PER_BIT > 1) ? 16'(CLKS_PER_BIT - 2) : 16'd0;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  data_q;
    logic        parity_q;
    logic        tx_q;
    logic        ready_q;
    logic        done_q;

    logic        parity_d;
    logic        bit_end;

    // Even mode: parity = XOR of data; odd mode inverts it.
    assign parity_d = (^data_in) ^ odd_sel;
    assign bit_end  = (cnt_q == BIT_LAST);

    // Frame sequencer with registered line, handshake and parity outputs.
    // NOTE: every register here uses <= so all branches see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (load) begin
                        data_q   <= data_in;
                        parity_q <= parity_d;
                        state_q  <= START;
                        tx_q     <= 1'b0;
                        ready_q  <= 1'b0;
                        cnt_q    <= '0;
                        idx_q    <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        tx_q    <= data_q[0];
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        // 3-bit index wraps 7 -> 0 exactly when leaving DATA.
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= PARITY;
                            tx_q    <= parity_q;
                        end else begin
                            tx_q <= data_q[idx_q + 3'd1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        tx_q  <= 1'b1;
                        if (CLKS_PER_BIT == 1) begin
                            // One-cycle stop bit is entirely the IDLE/done cycle.
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (cnt_q == STOP_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready      = ready_q;
    assign tx_out     = tx_q;
    assign parity_bit = parity_q;
    assign done       = done_q;

endmodule
